// File: rtl/accel_mem_arbiter_if.sv
// Signal bundle between the host port, the accelerator channels, the shared RAM port and the arbiter.
// The arbiter takes the slave view; requesters and RAM together take the master view.
interface accel_mem_arbiter_if #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_CH          = 2,
    parameter int STALL_CNT_WIDTH = 16
);
    logic                             accel_busy;
    logic                             host_req;
    logic                             host_gnt;
    logic [ADDR_WIDTH-1:0]            host_addr;
    logic                             host_we;
    logic [DATA_WIDTH/8-1:0]          host_be;
    logic [DATA_WIDTH-1:0]            host_wdata;
    logic                             host_rvalid;
    logic [DATA_WIDTH-1:0]            host_rdata;
    logic [NUM_CH-1:0]                ch_req;
    logic [NUM_CH-1:0]                ch_gnt;
    logic [NUM_CH*ADDR_WIDTH-1:0]     ch_addr;
    logic [NUM_CH-1:0]                ch_we;
    logic [NUM_CH*DATA_WIDTH/8-1:0]   ch_be;
    logic [NUM_CH*DATA_WIDTH-1:0]     ch_wdata;
    logic [NUM_CH-1:0]                ch_rvalid;
    logic [DATA_WIDTH-1:0]            ch_rdata;
    logic                             mem_en;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic                             mem_we;
    logic [DATA_WIDTH/8-1:0]          mem_be;
    logic [DATA_WIDTH-1:0]            mem_wdata;
    logic [DATA_WIDTH-1:0]            mem_rdata;
    logic [STALL_CNT_WIDTH-1:0]       host_stall_cycles;

    modport slave (
        input  accel_busy, host_req, host_addr, host_we, host_be, host_wdata,
               ch_req, ch_addr, ch_we, ch_be, ch_wdata, mem_rdata,
        output host_gnt, host_rvalid, host_rdata, ch_gnt, ch_rvalid, ch_rdata,
               mem_en, mem_addr, mem_we, mem_be, mem_wdata, host_stall_cycles
    );

    modport master (
        output accel_busy, host_req, host_addr, host_we, host_be, host_wdata,
               ch_req, ch_addr, ch_we, ch_be, ch_wdata, mem_rdata,
        input  host_gnt, host_rvalid, host_rdata, ch_gnt, ch_rvalid, ch_rdata,
               mem_en, mem_addr, mem_we, mem_be, mem_wdata, host_stall_cycles
    );
endinterface

// File: rtl/accel_mem_arbiter.sv
// Arbitrates one host port and NUM_CH round-robin accelerator channels onto a 1-cycle-latency RAM port,
// with an optional bounded wait after which a stalled host is forced through while the accelerator is busy.
module accel_mem_arbiter #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_CH          = 2,
    parameter int MAX_HOST_WAIT   = 8,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    accel_mem_arbiter_if.slave bus
);
    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int RR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WAIT_W = (MAX_HOST_WAIT > 0) ? $clog2(MAX_HOST_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_HOST_WAIT);
    localparam logic [RR_W-1:0]   LAST_CH  = RR_W'(NUM_CH - 1);

    logic [RR_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
    logic                       owner_vld_q, owner_vld_d;
    logic                       owner_host_q, owner_host_d;
    logic [RR_W-1:0]            owner_ch_q, owner_ch_d;
    logic                       ch_found;
    logic [RR_W-1:0]            ch_sel;
    logic                       force_host;
    logic                       gnt_host;
    logic                       gnt_ch;

    // Round-robin: lowest requester at or above rr_ptr, otherwise wrap to the lowest one below it.
    always_comb begin
        ch_found = 1'b0;
        ch_sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_found && bus.ch_req[i] && (i >= int'(rr_ptr_q))) begin
                ch_found = 1'b1;
                ch_sel   = RR_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_found && bus.ch_req[i] && (i < int'(rr_ptr_q))) begin
                ch_found = 1'b1;
                ch_sel   = RR_W'(i);
            end
        end
    end

    // wait_cnt saturates at WAIT_MAX, so equality is the threshold test.
    assign force_host = (MAX_HOST_WAIT != 0) && (wait_cnt_q == WAIT_MAX);

    always_comb begin
        gnt_host = 1'b0;
        gnt_ch   = 1'b0;
        if (!rst) begin
            if (!bus.accel_busy) begin
                gnt_host = bus.host_req;
                gnt_ch   = !bus.host_req && ch_found;
            end else begin
                gnt_host = bus.host_req && (force_host || !ch_found);
                gnt_ch   = !gnt_host && ch_found;
            end
        end
    end

    always_comb begin
        bus.host_gnt  = gnt_host;
        bus.ch_gnt    = '0;
        bus.mem_en    = gnt_host || gnt_ch;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        if (gnt_host) begin
            bus.mem_addr  = bus.host_addr;
            bus.mem_we    = bus.host_we;
            bus.mem_be    = bus.host_be;
            bus.mem_wdata = bus.host_wdata;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_ch && (ch_sel == RR_W'(i))) begin
                bus.ch_gnt[i] = 1'b1;
                bus.mem_addr  = bus.ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                bus.mem_we    = bus.ch_we[i];
                bus.mem_be    = bus.ch_be[i*BE_W +: BE_W];
                bus.mem_wdata = bus.ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_ch) begin
            rr_ptr_d = (ch_sel == LAST_CH) ? '0 : ch_sel + RR_W'(1);
        end
        wait_cnt_d = wait_cnt_q;
        if (!bus.host_req || gnt_host) begin
            wait_cnt_d = '0;
        end else if (bus.accel_busy && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        stall_d = stall_q;
        if (bus.host_req && !gnt_host && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_WIDTH'(1);
        end
        owner_vld_d  = gnt_host || gnt_ch;
        owner_host_d = gnt_host;
        owner_ch_d   = ch_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            stall_q     <= '0;
            owner_vld_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_q     <= stall_d;
            owner_vld_q <= owner_vld_d;
        end
    end

    // Owner id is only meaningful while owner_vld_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        owner_host_q <= owner_host_d;
        owner_ch_q   <= owner_ch_d;
    end

    always_comb begin
        bus.host_rvalid = !rst && owner_vld_q && owner_host_q;
        bus.ch_rvalid   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bus.ch_rvalid[i] = !rst && owner_vld_q && !owner_host_q && (owner_ch_q == RR_W'(i));
        end
    end

    assign bus.host_rdata        = bus.mem_rdata;
    assign bus.ch_rdata          = bus.mem_rdata;
    assign bus.host_stall_cycles = stall_q;
endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Bench for accel_mem_arbiter: priority table, hand-written multi-cycle sequences and a randomized run
// against a behavioural arbitration model. A second instance with the host-force limit disabled covers starvation.
module tb_accel_mem_arbiter;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int NC   = 2;
    localparam int BW   = DW / 8;
    localparam int SW   = 16;
    localparam int MAXW = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    accel_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .STALL_CNT_WIDTH(SW)) bus ();
    accel_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .STALL_CNT_WIDTH(SW)) bus0 ();

    accel_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .MAX_HOST_WAIT(MAXW), .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    accel_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .MAX_HOST_WAIT(0), .STALL_CNT_WIDTH(SW)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    // Simple 1-cycle-latency byte-writable RAM behind the main instance.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            ram_q <= ram[bus.mem_addr];
            if (bus.mem_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.mem_be[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
    end
    assign bus.mem_rdata  = ram_q;
    assign bus0.mem_rdata = '0;

    typedef struct {
        logic          busy;
        logic          hreq;
        logic [NC-1:0] creq;
        logic          exp_hg;
        logic [NC-1:0] exp_cg;
        logic [AW-1:0] exp_addr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.accel_busy  = 1'b0;  bus0.accel_busy  = 1'b0;
        bus.host_req    = 1'b0;  bus0.host_req    = 1'b0;
        bus.host_addr   = '0;    bus0.host_addr   = '0;
        bus.host_we     = 1'b0;  bus0.host_we     = 1'b0;
        bus.host_be     = '0;    bus0.host_be     = '0;
        bus.host_wdata  = '0;    bus0.host_wdata  = '0;
        bus.ch_req      = '0;    bus0.ch_req      = '0;
        bus.ch_we       = '0;    bus0.ch_we       = '0;
        bus.ch_be       = '0;    bus0.ch_be       = '0;
        bus.ch_wdata    = '0;    bus0.ch_wdata    = '0;
        for (int i = 0; i < NC; i++) begin
            bus.ch_addr[i*AW +: AW]  = AW'(256 + i);
            bus0.ch_addr[i*AW +: AW] = AW'(256 + i);
        end
    endtask

    // Leaves the caller at a falling edge with rst low, ready to drive the first live cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_random(input int ncyc);
        int            m_rr, m_wait, m_stall, m_owner, w, c, drop;
        logic          busy;
        logic [NC-1:0] exp_cg, exp_cv;
        logic [AW-1:0] exp_addr;
        logic          exp_we;
        m_rr = 0; m_wait = 0; m_stall = 0; m_owner = -1; drop = -1; busy = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            if (drop == NC) bus.host_req = 1'b0;
            else if (drop >= 0) bus.ch_req[drop] = 1'b0;
            if ($urandom_range(15) == 0) busy = ~busy;
            bus.accel_busy = busy;
            if (!bus.host_req && $urandom_range(2) != 0) begin
                bus.host_req   = 1'b1;
                bus.host_addr  = AW'($urandom);
                bus.host_we    = 1'($urandom);
                bus.host_be    = BW'($urandom);
                bus.host_wdata = $urandom;
            end
            for (int i = 0; i < NC; i++) begin
                if (!bus.ch_req[i] && $urandom_range(3) != 0) begin
                    bus.ch_req[i]            = 1'b1;
                    bus.ch_addr[i*AW +: AW]  = AW'($urandom);
                    bus.ch_we[i]             = 1'($urandom);
                    bus.ch_be[i*BW +: BW]    = BW'($urandom);
                    bus.ch_wdata[i*DW +: DW] = $urandom;
                end
            end
            c = -1;
            for (int k = 0; k < NC; k++) begin
                if (c < 0 && bus.ch_req[(m_rr + k) % NC]) c = (m_rr + k) % NC;
            end
            if (bus.host_req && (!busy || m_wait >= MAXW || c < 0)) w = NC;
            else w = c;
            exp_cg   = (w >= 0 && w < NC) ? NC'(1 << w) : '0;
            exp_cv   = (m_owner >= 0 && m_owner < NC) ? NC'(1 << m_owner) : '0;
            exp_addr = (w == NC) ? bus.host_addr : (w >= 0) ? bus.ch_addr[w*AW +: AW] : '0;
            exp_we   = (w == NC) ? bus.host_we : (w >= 0) ? bus.ch_we[w] : 1'b0;
            #1;
            chk("rnd_host_gnt", 64'(bus.host_gnt), 64'(w == NC));
            chk("rnd_ch_gnt", 64'(bus.ch_gnt), 64'(exp_cg));
            chk("rnd_mem_en", 64'(bus.mem_en), 64'(w >= 0));
            chk("rnd_mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
            chk("rnd_mem_we", 64'(bus.mem_we), 64'(exp_we));
            chk("rnd_host_rvalid", 64'(bus.host_rvalid), 64'(m_owner == NC));
            chk("rnd_ch_rvalid", 64'(bus.ch_rvalid), 64'(exp_cv));
            chk("rnd_stall", 64'(bus.host_stall_cycles), 64'(m_stall));
            if (w >= 0 && w < NC) m_rr = (w + 1) % NC;
            if (!bus.host_req || w == NC) m_wait = 0;
            else if (busy && m_wait < MAXW) m_wait++;
            if (bus.host_req && w != NC && m_stall < 65535) m_stall++;
            m_owner = w;
            drop    = w;
            @(negedge clk);
        end
    endtask

    vec_t          tbl [8];
    logic [NC-1:0] seq2 [4];
    logic [NC-1:0] prev;

    initial begin
        rst = 1'b1;
        idle_inputs();
        tbl[0] = '{1'b0, 1'b1, 2'b11, 1'b1, 2'b00, 10'h033};
        tbl[1] = '{1'b0, 1'b0, 2'b11, 1'b0, 2'b01, 10'h100};
        tbl[2] = '{1'b0, 1'b0, 2'b10, 1'b0, 2'b10, 10'h101};
        tbl[3] = '{1'b1, 1'b1, 2'b10, 1'b0, 2'b10, 10'h101};
        tbl[4] = '{1'b1, 1'b1, 2'b00, 1'b1, 2'b00, 10'h033};
        tbl[5] = '{1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 10'h000};
        tbl[6] = '{1'b0, 1'b1, 2'b00, 1'b1, 2'b00, 10'h033};
        tbl[7] = '{1'b1, 1'b1, 2'b01, 1'b0, 2'b01, 10'h100};
        seq2[0] = 2'b01; seq2[1] = 2'b10; seq2[2] = 2'b01; seq2[3] = 2'b10;

        // Reset state.
        do_reset();
        #1;
        chk("rst_host_rvalid", 64'(bus.host_rvalid), 64'd0);
        chk("rst_ch_rvalid", 64'(bus.ch_rvalid), 64'd0);
        chk("rst_stall", 64'(bus.host_stall_cycles), 64'd0);
        chk("rst_mem_en", 64'(bus.mem_en), 64'd0);

        // Single-cycle priority table, each vector from a fresh reset.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            bus.host_addr  = 10'h033;
            bus.accel_busy = tbl[t].busy;
            bus.host_req   = tbl[t].hreq;
            bus.ch_req     = tbl[t].creq;
            #1;
            chk($sformatf("tbl%0d_host_gnt", t), 64'(bus.host_gnt), 64'(tbl[t].exp_hg));
            chk($sformatf("tbl%0d_ch_gnt", t), 64'(bus.ch_gnt), 64'(tbl[t].exp_cg));
            chk($sformatf("tbl%0d_mem_en", t), 64'(bus.mem_en), 64'(tbl[t].exp_hg | (|tbl[t].exp_cg)));
            chk($sformatf("tbl%0d_mem_addr", t), 64'(bus.mem_addr), 64'(tbl[t].exp_addr));
        end

        // Host write then read-back.
        do_reset();
        bus.host_req = 1'b1; bus.host_addr = 10'd5; bus.host_we = 1'b1;
        bus.host_be = 4'hF; bus.host_wdata = 32'hDEADBEEF;
        #1;
        chk("t1_wr_gnt", 64'(bus.host_gnt), 64'd1);
        chk("t1_wr_we", 64'(bus.mem_we), 64'd1);
        chk("t1_wr_data", 64'(bus.mem_wdata), 64'hDEADBEEF);
        @(negedge clk);
        bus.host_we = 1'b0; bus.host_wdata = '0;
        #1;
        chk("t1_wr_rvalid", 64'(bus.host_rvalid), 64'd1);
        chk("t1_rd_gnt", 64'(bus.host_gnt), 64'd1);
        @(negedge clk);
        bus.host_req = 1'b0;
        #1;
        chk("t1_rd_rvalid", 64'(bus.host_rvalid), 64'd1);
        chk("t1_rd_data", 64'(bus.host_rdata), 64'hDEADBEEF);

        // Two channels, busy: alternating grants with one-cycle-late rvalids.
        do_reset();
        bus.accel_busy = 1'b1; bus.ch_req = 2'b11;
        prev = '0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("t2_gnt%0d", k), 64'(bus.ch_gnt), 64'(seq2[k]));
            chk($sformatf("t2_rvalid%0d", k), 64'(bus.ch_rvalid), 64'(prev));
            prev = seq2[k];
        end
        @(negedge clk);
        bus.ch_req = '0;
        #1;
        chk("t2_last_rvalid", 64'(bus.ch_rvalid), 64'(2'b10));
        chk("t2_idle_gnt", 64'(bus.ch_gnt), 64'd0);

        // Forced host grant after MAXW stalled cycles.
        do_reset();
        bus.accel_busy = 1'b1; bus.ch_req = 2'b11; bus.host_req = 1'b1; bus.host_addr = 10'h033;
        for (int k = 1; k <= MAXW; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            chk($sformatf("t3_wait%0d", k), 64'(bus.host_gnt), 64'd0);
        end
        @(negedge clk);
        #1;
        chk("t3_forced_gnt", 64'(bus.host_gnt), 64'd1);
        chk("t3_forced_ch_gnt", 64'(bus.ch_gnt), 64'd0);
        chk("t3_stall", 64'(bus.host_stall_cycles), 64'd8);
        chk("t3_forced_addr", 64'(bus.mem_addr), 64'h033);
        @(negedge clk);
        bus.host_req = 1'b0;
        #1;
        chk("t3_host_rvalid", 64'(bus.host_rvalid), 64'd1);
        chk("t3_resume0", 64'(bus.ch_gnt), 64'(2'b01));
        @(negedge clk);
        #1;
        chk("t3_resume1", 64'(bus.ch_gnt), 64'(2'b10));
        chk("t3_stall_held", 64'(bus.host_stall_cycles), 64'd8);

        // No forcing: host waits for as long as a channel keeps requesting.
        do_reset();
        bus0.accel_busy = 1'b1; bus0.ch_req = 2'b01; bus0.host_req = 1'b1; bus0.host_addr = 10'h044;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("t4_host_held%0d", k), 64'(bus0.host_gnt), 64'd0);
            chk($sformatf("t4_ch_gnt%0d", k), 64'(bus0.ch_gnt), 64'(2'b01));
        end
        @(negedge clk);
        bus0.ch_req = '0;
        #1;
        chk("t4_host_gnt", 64'(bus0.host_gnt), 64'd1);
        chk("t4_stall", 64'(bus0.host_stall_cycles), 64'd20);

        // Idle accelerator: host before channel 1, address follows the grant.
        do_reset();
        bus.host_req = 1'b1; bus.host_addr = 10'h033; bus.ch_req = 2'b10;
        #1;
        chk("t5_host_gnt", 64'(bus.host_gnt), 64'd1);
        chk("t5_ch_gnt_blocked", 64'(bus.ch_gnt), 64'd0);
        chk("t5_host_addr", 64'(bus.mem_addr), 64'h033);
        @(negedge clk);
        bus.host_req = 1'b0;
        #1;
        chk("t5_ch1_gnt", 64'(bus.ch_gnt), 64'(2'b10));
        chk("t5_ch1_addr", 64'(bus.mem_addr), 64'h101);
        chk("t5_host_rvalid", 64'(bus.host_rvalid), 64'd1);
        @(negedge clk);
        bus.ch_req = '0;
        #1;
        chk("t5_ch1_rvalid", 64'(bus.ch_rvalid), 64'(2'b10));
        chk("t5_idle_en", 64'(bus.mem_en), 64'd0);

        // Reset right after a channel grant drops the response and rewinds rr_ptr.
        do_reset();
        bus.ch_req = 2'b01;
        #1;
        chk("t6_ch0_gnt", 64'(bus.ch_gnt), 64'(2'b01));
        @(negedge clk);
        rst = 1'b1; bus.ch_req = 2'b11; bus.host_req = 1'b1;
        #1;
        chk("t6_rst_ch_gnt", 64'(bus.ch_gnt), 64'd0);
        chk("t6_rst_host_gnt", 64'(bus.host_gnt), 64'd0);
        chk("t6_rst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("t6_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("t6_rst_ch_rvalid", 64'(bus.ch_rvalid), 64'd0);
        @(negedge clk);
        #1;
        chk("t6_rst2_ch_rvalid", 64'(bus.ch_rvalid), 64'd0);
        chk("t6_rst2_stall", 64'(bus.host_stall_cycles), 64'd0);
        @(negedge clk);
        rst = 1'b0; bus.host_req = 1'b0;
        #1;
        chk("t6_post_rvalid", 64'(bus.ch_rvalid), 64'd0);
        chk("t6_post_gnt", 64'(bus.ch_gnt), 64'(2'b01));

        // Randomized traffic against the reference model.
        do_reset();
        run_random(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
